// File: rtl/load_store_unit.sv
// Load/store unit between the CPU memory stage and a word-addressed data memory.
// Optional macro MISALIGN_TRAP_EN: misaligned requests complete at once with rsp_err set.
module load_store_unit #(
  parameter int M          = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [M-1:0] req_addr,
  input  logic [M-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [M-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_we,
  output logic [M-1:0] mem_a,
  output logic [M-1:0] mem_wd,
  input  logic [M-1:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t       state_reg, state_next;
  logic         accept;
  logic         trap_req;
  logic [M-1:0] addr_reg;
  logic [1:0]   size_reg;
  logic         uns_reg;
  logic [15:0]  wdata_reg;
  logic [M-1:0] wr_word_reg;
  logic [M-1:0] rsp_rdata_reg;

  logic [1:0]   byte_lane;
  logic         half_hi;
  logic [7:0]   rd_bytes [4];
  logic [7:0]   byte_field;
  logic [15:0]  half_field;
  logic [M-1:0] load_ext;
  logic [3:0]   lane_en;
  logic [M-1:0] lane_data;
  logic [M-1:0] merged;

  assign accept = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
  assign trap_req = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign trap_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (trap_req)         state_next = RESP;
          else if (!req_we)     state_next = LOAD;
          else if (req_size[1]) state_next = WRITE;
          else                  state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and memory strobes decode straight from state so reset kills them at once.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    case (state_reg)
      IDLE:    req_ready = 1'b1;
      WRITE:   mem_we    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign byte_lane  = BIG_ENDIAN ? ~addr_reg[1:0] : addr_reg[1:0];
  assign half_hi    = BIG_ENDIAN ? ~addr_reg[1] : addr_reg[1];
  assign byte_field = rd_bytes[byte_lane];
  assign half_field = half_hi ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_ext = {{(M-8){~uns_reg & byte_field[7]}}, byte_field};
      2'b01:   load_ext = {{(M-16){~uns_reg & half_field[15]}}, half_field};
      default: load_ext = mem_rd;
    endcase
  end

  // Store data replicated across lanes; lane_en picks which lanes replace the read word.
  assign lane_en   = size_reg[0] ? (half_hi ? 4'b1100 : 4'b0011) : (4'b0001 << byte_lane);
  assign lane_data = size_reg[0] ? {2{wdata_reg}} : {4{wdata_reg[7:0]}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_bytes[gi]      = mem_rd[8*gi +: 8];
    assign merged[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8] : mem_rd[8*gi +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      size_reg      <= '0;
      uns_reg       <= 1'b0;
      wdata_reg     <= '0;
      wr_word_reg   <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg      <= req_addr;
            size_reg      <= req_size;
            uns_reg       <= req_unsigned;
            wdata_reg     <= req_wdata[15:0];
            wr_word_reg   <= req_wdata;
            rsp_rdata_reg <= '0;
          end
        end
        RMW_RD:  wr_word_reg   <= merged;
        LOAD:    rsp_rdata_reg <= load_ext;
        RESP:    rsp_rdata_reg <= '0;
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_reg <= 1'b0;
    else if (accept)             err_reg <= trap_req;
    else if (state_reg == RESP)  err_reg <= 1'b0;
  end

  assign rsp_err = err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  assign mem_a     = {addr_reg[M-1:2], 2'b00};
  assign mem_wd    = wr_word_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus back-to-back and mid-operation reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  logic        tb_wr;
  logic [5:0]  tb_wa;
  logic [31:0] tb_wd;

  int tests = 0;
  int fails = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.M(32), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_a[7:2]] <= mem_wd;
    else if (tb_wr) mem[tb_wa]      <= tb_wd;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] init, input logic [31:0] exp_rdata,
                              input logic [31:0] exp_mem, input int exp_lat, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.init = init; v.exp_rdata = exp_rdata; v.exp_mem = exp_mem;
    v.exp_lat = exp_lat; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    tb_wr = 1'b1; tb_wa = idx; tb_wd = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int we_cnt, output logic [31:0] a_seen);
    lat = 0; we_cnt = 0; rdata = 32'hxxxxxxxx; err = 1'bx; a_seen = 32'hxxxxxxxx;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (rsp_valid) begin
        lat = c; rdata = rsp_rdata; err = rsp_err; a_seen = mem_a;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, we_cnt, exp_we, we_seen, vld_seen;
    logic [31:0] rdata, a_seen, rd_seen;
    logic        err;
    logic [5:0]  rdy_pat, vld_pat;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;

    // Loads over 0x8899AABB at 0x40 and 0x12345678 at 0x48
    vecs[0]  = mk(0, 2'b00, 0, 32'h41, 0, 32'h8899AABB, 32'hFFFFFFAA, 32'h8899AABB, 2, 0);
    vecs[1]  = mk(0, 2'b01, 1, 32'h42, 0, 32'h8899AABB, 32'h00008899, 32'h8899AABB, 2, 0);
    vecs[2]  = mk(0, 2'b01, 0, 32'h42, 0, 32'h8899AABB, 32'hFFFF8899, 32'h8899AABB, 2, 0);
    vecs[3]  = mk(0, 2'b00, 1, 32'h40, 0, 32'h8899AABB, 32'h000000BB, 32'h8899AABB, 2, 0);
    vecs[4]  = mk(0, 2'b00, 0, 32'h43, 0, 32'h8899AABB, 32'hFFFFFF88, 32'h8899AABB, 2, 0);
    vecs[5]  = mk(0, 2'b01, 0, 32'h40, 0, 32'h8899AABB, 32'hFFFFAABB, 32'h8899AABB, 2, 0);
    vecs[6]  = mk(0, 2'b00, 0, 32'h49, 0, 32'h12345678, 32'h00000056, 32'h12345678, 2, 0);
    vecs[7]  = mk(0, 2'b01, 0, 32'h4A, 0, 32'h12345678, 32'h00001234, 32'h12345678, 2, 0);
    vecs[8]  = mk(0, 2'b10, 0, 32'h40, 0, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 2, 0);
    vecs[9]  = mk(0, 2'b11, 1, 32'h40, 0, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 2, 0);
    // Stores
    vecs[10] = mk(1, 2'b00, 0, 32'h43, 32'h0000005C, 32'h8899AABB, 32'h0, 32'h5C99AABB, 3, 0);
    vecs[11] = mk(1, 2'b00, 0, 32'h40, 32'h1234567F, 32'h8899AABB, 32'h0, 32'h8899AA7F, 3, 0);
    vecs[12] = mk(1, 2'b01, 0, 32'h46, 32'h0000CAFE, 32'h8899AABB, 32'h0, 32'hCAFEAABB, 3, 0);
    vecs[13] = mk(1, 2'b01, 0, 32'h44, 32'hFFFFBEEF, 32'h8899AABB, 32'h0, 32'h8899BEEF, 3, 0);
    vecs[14] = mk(1, 2'b10, 0, 32'h80, 32'hDEADBEEF, 32'h00000000, 32'h0, 32'hDEADBEEF, 2, 0);
    // Misaligned: masked by default, trapped with the macro
    vecs[15] = mk(0, 2'b10, 0, 32'h46, 0, 32'h11223344, TRAP ? 32'h0 : 32'h11223344,
                  32'h11223344, TRAP ? 1 : 2, TRAP);
    vecs[16] = mk(0, 2'b01, 0, 32'h43, 0, 32'h8899AABB, TRAP ? 32'h0 : 32'hFFFF8899,
                  32'h8899AABB, TRAP ? 1 : 2, TRAP);
    vecs[17] = mk(1, 2'b10, 0, 32'h42, 32'h01020304, 32'h55667788, 32'h0,
                  TRAP ? 32'h55667788 : 32'h01020304, TRAP ? 1 : 2, TRAP);
    vecs[18] = mk(1, 2'b01, 0, 32'h45, 32'h00001111, 32'hAABBCCDD, 32'h0,
                  TRAP ? 32'hAABBCCDD : 32'hAABB1111, TRAP ? 1 : 3, TRAP);

    // Reset state
    @(negedge clk);
    #1;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_rsp_err", rsp_err, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      poke(vecs[i].addr[7:2], vecs[i].init);
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              lat, rdata, err, we_cnt, a_seen);
      $display("[TB] vec %0d we=%0d size=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%b lat=%0d we_pulses=%0d",
               i, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rdata, err, lat, we_cnt);
      exp_we = (vecs[i].we && !vecs[i].exp_err) ? 1 : 0;
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check1($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_we_pulses", i), we_cnt, exp_we);
      check($sformatf("v%0d_mem_a", i), a_seen, {vecs[i].addr[31:2], 2'b00});
      @(negedge clk);
      check1($sformatf("v%0d_ready_after", i), req_ready, 1'b1);
      check($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
    end

    // Back-to-back: sw 0xDEADBEEF to 0x80, then lw 0x80 with req_valid held
    poke(6'd32, 32'h0);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h80; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    check1("b2b_ready_first", req_ready, 1'b1);
    rdy_pat = '0; vld_pat = '0; rd_seen = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rdy_pat[c] = req_ready;
      vld_pat[c] = rsp_valid;
      if (rsp_valid && c >= 3) rd_seen = rsp_rdata;
      if (c == 0) begin req_we = 1'b0; req_wdata = '0; end
      if (c == 4) req_valid = 1'b0;
    end
    $display("[TB] b2b sw/lw 0x80 ready=%b valid=%b rdata=0x%08h", rdy_pat, vld_pat, rd_seen);
    check("b2b_ready_pattern", {26'b0, rdy_pat}, 32'b100100);
    check("b2b_valid_pattern", {26'b0, vld_pat}, 32'b010010);
    check("b2b_load_data", rd_seen, 32'hDEADBEEF);
    check("b2b_mem_word", mem[32], 32'hDEADBEEF);

    // Reset while in RMW_RD of sh to 0x44
    poke(6'd17, 32'h8899AABB);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h44; req_wdata = 32'h00001234; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("rmwrst_mem_we", mem_we, 1'b0);
    check1("rmwrst_rsp_valid", rsp_valid, 1'b0);
    check("rmwrst_rsp_rdata", rsp_rdata, 32'h0);
    check("rmwrst_mem_a", mem_a, 32'h0);
    check("rmwrst_mem_wd", mem_wd, 32'h0);
    we_seen = 0; vld_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (rsp_valid) vld_seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (rsp_valid) vld_seen++;
    end
    $display("[TB] reset in RMW_RD: we_pulses=%0d rsp_pulses=%0d mem=0x%08h", we_seen, vld_seen, mem[17]);
    check("rmwrst_we_pulses", we_seen, 0);
    check("rmwrst_rsp_pulses", vld_seen, 0);
    check("rmwrst_mem_word", mem[17], 32'h8899AABB);
    check1("rmwrst_ready_after", req_ready, 1'b1);

    // Reset during WRITE of sb to 0x44: mem_we must drop before the edge
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h44; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("wrrst_we_before", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("wrrst_we_dropped", mem_we, 1'b0);
    vld_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) vld_seen++;
    end
    $display("[TB] reset in WRITE: rsp_pulses=%0d mem=0x%08h", vld_seen, mem[17]);
    check("wrrst_rsp_pulses", vld_seen, 0);
    check("wrrst_mem_word", mem[17], 32'h8899AABB);
    check1("wrrst_ready_after", req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
